// File: rtl/rtap_core_req_ctl.sv
// Rtap-side request controller for the rtap<->core JTAG debug protocol.
// Issues a one-cycle request pulse, OR-merges the core response window, and returns it to the TAP.
`ifndef CORE_JTAG_BUS_WIDTH
`define CORE_JTAG_BUS_WIDTH 16
`endif
`ifndef JTAG_CORE_ID_WIDTH
`define JTAG_CORE_ID_WIDTH 5
`endif

module rtap_core_req_ctl #(
  parameter int WINDOW = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_jtag_req_val,
  output logic                            o_jtag_req_rdy,
  input  logic [1:0]                      i_jtag_req_threadid,
  input  logic [`JTAG_CORE_ID_WIDTH-1:0]  i_jtag_req_id,
  input  logic [`CORE_JTAG_BUS_WIDTH-1:0] i_jtag_req_data,
  output logic                            o_jtag_resp_val,
  input  logic                            i_jtag_resp_ack,
  output logic [`CORE_JTAG_BUS_WIDTH-1:0] o_jtag_resp_data,
  output logic                            o_jtag_resp_multi,
  output logic                            o_rtap_core_val,
  output logic [1:0]                      o_rtap_core_threadid,
  output logic [`JTAG_CORE_ID_WIDTH-1:0]  o_rtap_core_id,
  output logic [`CORE_JTAG_BUS_WIDTH-1:0] o_rtap_core_data,
  input  logic [`CORE_JTAG_BUS_WIDTH-1:0] i_core_rtap_data
);

  localparam int BW = `CORE_JTAG_BUS_WIDTH;
  localparam logic [3:0] LAST_SAMPLE = 4'(WINDOW - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_cnt;
  logic [1:0]      r_hits;
  logic [BW-1:0]   r_acc;

  logic            w_accept;
  logic            w_last;
  logic            w_hit;
  logic [1:0]      w_hits_nxt;
  logic [BW-1:0]   w_acc_nxt;

  assign o_jtag_req_rdy = (r_state == S_IDLE);
  assign w_accept       = i_jtag_req_val && (r_state == S_IDLE);
  assign w_last         = (r_cnt == LAST_SAMPLE);
  assign w_hit          = |i_core_rtap_data;
  assign w_hits_nxt     = (r_hits == 2'd3) ? 2'd3 : r_hits + {1'b0, w_hit};
  assign w_acc_nxt      = r_acc | i_core_rtap_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_last) w_next = S_DONE;
      S_DONE:  if (i_jtag_resp_ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request bus defaults to zero every cycle so it is only nonzero during ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rtap_core_val      <= 1'b0;
      o_rtap_core_threadid <= '0;
      o_rtap_core_id       <= '0;
      o_rtap_core_data     <= '0;
      o_jtag_resp_val      <= 1'b0;
      o_jtag_resp_data     <= '0;
      o_jtag_resp_multi    <= 1'b0;
      r_cnt                <= '0;
      r_hits               <= '0;
      r_acc                <= '0;
    end else begin
      o_rtap_core_val      <= 1'b0;
      o_rtap_core_threadid <= '0;
      o_rtap_core_id       <= '0;
      o_rtap_core_data     <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            o_rtap_core_val      <= 1'b1;
            o_rtap_core_threadid <= i_jtag_req_threadid;
            o_rtap_core_id       <= i_jtag_req_id;
            o_rtap_core_data     <= i_jtag_req_data;
          end
        end
        S_ISSUE: begin
          r_acc  <= '0;
          r_cnt  <= '0;
          r_hits <= '0;
        end
        S_WAIT: begin
          r_acc  <= w_acc_nxt;
          r_hits <= w_hits_nxt;
          r_cnt  <= r_cnt + 4'd1;
          if (w_last) begin
            o_jtag_resp_val   <= 1'b1;
            o_jtag_resp_data  <= w_acc_nxt;
            o_jtag_resp_multi <= w_hits_nxt[1];
          end
        end
        S_DONE: begin
          if (i_jtag_resp_ack) o_jtag_resp_val <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
